// File: rtl/prog_clock_divider_if.sv
// Control/status bundle for prog_clock_divider: per-channel enables, divisor
// write port, and the per-channel divided outputs.
interface prog_clock_divider_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] enable_i;
    logic                sync_i;
    logic                wr_en_i;
    logic [CW-1:0]       wr_channel_i;
    logic [WIDTH-1:0]    wr_divisor_i;
    logic [CHANNELS-1:0] pending_o;
    logic [CHANNELS-1:0] out_o;
    logic [CHANNELS-1:0] tick_o;

    modport master (
        output enable_i, sync_i, wr_en_i, wr_channel_i, wr_divisor_i,
        input  pending_o, out_o, tick_o
    );

    modport slave (
        input  enable_i, sync_i, wr_en_i, wr_channel_i, wr_divisor_i,
        output pending_o, out_o, tick_o
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel holds an active and a
// shadow divisor; the shadow is promoted only at a wrap, sync or while idle.
module prog_clock_divider_ch #(
    parameter int WIDTH         = 16,
    parameter int RESET_DIVISOR = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_pending,
    output logic             o_out,
    output logic             o_tick
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;
    logic             r_out;
    logic             r_tick;
    logic             w_wrap;
    logic             w_apply;

    assign w_wrap  = (r_count == r_active);
    // Every point where a half-period starts fresh is a safe place to swap divisors.
    assign w_apply = i_sync | ~i_enable | w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_active  <= WIDTH'(RESET_DIVISOR);
            r_shadow  <= WIDTH'(RESET_DIVISOR);
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (i_sync || !i_enable) begin
                r_count <= '0;
                r_out   <= 1'b0;
                r_tick  <= 1'b0;
            end else if (w_wrap) begin
                r_count <= '0;
                r_out   <= ~r_out;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + WIDTH'(1);
                r_tick  <= 1'b0;
            end

            if (w_apply && r_pending)
                r_active <= r_shadow;

            // A write landing on an apply point promotes the old shadow and stays pending.
            if (i_wr) begin
                r_shadow  <= i_divisor;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_out     = r_out;
    assign o_tick    = r_tick;
endmodule

module prog_clock_divider #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 16,
    parameter int RESET_DIVISOR = 9
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    prog_clock_divider_if.slave  bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_wr_sel;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Indices past CHANNELS-1 match no channel, so such writes are dropped.
        assign w_wr_sel[g] = bus.wr_en_i && (bus.wr_channel_i == CW'(g));

        prog_clock_divider_ch #(
            .WIDTH         (WIDTH),
            .RESET_DIVISOR (RESET_DIVISOR)
        ) u_ch (
            .i_clk     (clock_i),
            .i_rst     (reset_i),
            .i_enable  (bus.enable_i[g]),
            .i_sync    (bus.sync_i),
            .i_wr      (w_wr_sel[g]),
            .i_divisor (bus.wr_divisor_i),
            .o_pending (bus.pending_o[g]),
            .o_out     (bus.out_o[g]),
            .o_tick    (bus.tick_o[g])
        );
    end
endmodule
